// File: rtl/median_filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : median_filter_pkg
// Description : Shared types for the median filter pixel path.
// Revision    : 1.0 - initial release
// ============================================================================
package median_filter_pkg;

    localparam int PIXEL_W = 8;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } streamer_state_e;

    typedef struct packed {
        pixel_t pixel;
        logic   sof;
        logic   eol;
    } pix_beat_t;

endpackage
`default_nettype wire

// File: rtl/pixel_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pixel_skid_fifo
// Description : Two-entry FIFO holding tagged pixel beats; head is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_skid_fifo
    import median_filter_pkg::*;
#(
    parameter type BEAT_T = pix_beat_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  BEAT_T      push_data,
    input  logic       pop,
    output BEAT_T      head,
    output logic [1:0] count
);

    BEAT_T      r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_do_push;
    logic       w_do_pop;

    // A simultaneous push/pop is honoured even when full or empty.
    assign w_do_push = push && ((r_count != 2'd2) || pop);
    assign w_do_pop  = pop  && ((r_count != 2'd0) || push);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pixel_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_frame_streamer
// Description : Reads one frame from a sync-read RAM and streams it in raster
//               order with valid/ready, start-of-frame and end-of-line tags.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_frame_streamer #(
    parameter int IMAGE_LEN    = 1080,
    parameter int IMAGE_HEIGHT = 720,
    parameter int PIXEL_W      = 8,
    parameter int ADDR_W       = (IMAGE_LEN * IMAGE_HEIGHT > 1) ?
                                 $clog2(IMAGE_LEN * IMAGE_HEIGHT) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               rd_en_o,
    output logic [ADDR_W-1:0]  rd_addr_o,
    input  logic [PIXEL_W-1:0] rd_data_i,
    output logic [PIXEL_W-1:0] pixel_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               sof_o,
    output logic               eol_o
);
    import median_filter_pkg::*;

    localparam int c_num_pix = IMAGE_LEN * IMAGE_HEIGHT;
    localparam int c_col_w   = (IMAGE_LEN > 1) ? $clog2(IMAGE_LEN) : 1;
    localparam int c_row_w   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [ADDR_W-1:0]  c_last_addr = ADDR_W'(c_num_pix - 1);
    localparam logic [c_col_w-1:0] c_last_col  = c_col_w'(IMAGE_LEN - 1);
    localparam logic [c_row_w-1:0] c_last_row  = c_row_w'(IMAGE_HEIGHT - 1);

    typedef struct packed {
        logic [PIXEL_W-1:0] pixel;
        logic               sof;
        logic               eol;
    } beat_t;

    streamer_state_e    r_state;
    streamer_state_e    w_state_nxt;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [c_col_w-1:0] r_rd_col;
    logic [c_row_w-1:0] r_rd_row;
    logic [c_col_w-1:0] r_out_col;
    logic [c_row_w-1:0] r_out_row;
    logic               r_rd_pending;
    logic               r_tag_sof;
    logic               r_tag_eol;
    logic               w_start;
    logic               w_issue;
    logic               w_xfer;
    logic               w_out_last;
    logic               w_valid;
    logic [2:0]         w_credit;
    logic [1:0]         w_fifo_count;
    beat_t              w_push_beat;
    beat_t              w_head;

    // Slots already committed: stored beats plus the read landing this cycle,
    // less the beat leaving this cycle.
    assign w_credit   = 3'(w_fifo_count) + 3'(r_rd_pending) - 3'(w_xfer);
    assign w_valid    = (w_fifo_count != 2'd0);
    assign w_xfer     = w_valid && ready_i;
    assign w_out_last = (r_out_row == c_last_row) && (r_out_col == c_last_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_issue     = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                busy_o  = 1'b1;
                w_issue = (w_credit < 3'd2);
                if (w_issue && (r_rd_addr == c_last_addr)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (w_xfer && w_out_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done_o      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr    <= '0;
            r_rd_col     <= '0;
            r_rd_row     <= '0;
            r_out_col    <= '0;
            r_out_row    <= '0;
            r_rd_pending <= 1'b0;
            r_tag_sof    <= 1'b0;
            r_tag_eol    <= 1'b0;
        end else begin
            r_rd_pending <= w_issue;
            if (w_issue) begin
                r_tag_sof <= (r_rd_row == '0) && (r_rd_col == '0);
                r_tag_eol <= (r_rd_col == c_last_col);
            end
            if (w_start) begin
                r_rd_addr <= '0;
                r_rd_col  <= '0;
                r_rd_row  <= '0;
                r_out_col <= '0;
                r_out_row <= '0;
            end else begin
                if (w_issue) begin
                    if (r_rd_addr != c_last_addr) begin
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    end
                    if (r_rd_col == c_last_col) begin
                        r_rd_col <= '0;
                        if (r_rd_row != c_last_row) begin
                            r_rd_row <= r_rd_row + c_row_w'(1);
                        end
                    end else begin
                        r_rd_col <= r_rd_col + c_col_w'(1);
                    end
                end
                if (w_xfer) begin
                    if (r_out_col == c_last_col) begin
                        r_out_col <= '0;
                        if (r_out_row != c_last_row) begin
                            r_out_row <= r_out_row + c_row_w'(1);
                        end
                    end else begin
                        r_out_col <= r_out_col + c_col_w'(1);
                    end
                end
            end
        end
    end

    assign w_push_beat = {rd_data_i, r_tag_sof, r_tag_eol};

    pixel_skid_fifo #(
        .BEAT_T    (beat_t)
    ) u_skid_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_rd_pending),
        .push_data (w_push_beat),
        .pop       (w_xfer),
        .head      (w_head),
        .count     (w_fifo_count)
    );

    assign rd_en_o   = w_issue;
    assign rd_addr_o = r_rd_addr;
    assign valid_o   = w_valid;
    assign pixel_o   = w_valid ? w_head.pixel : '0;
    assign sof_o     = w_valid && w_head.sof;
    assign eol_o     = w_valid && w_head.eol;

endmodule
`default_nettype wire

// File: tb/tb_pixel_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_frame_streamer
// Description : Randomised self-checking bench for a 4x3 and a 1x1 streamer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_frame_streamer;

    localparam int L  = 4;
    localparam int H  = 3;
    localparam int N  = L * H;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n, start_i, ready_i;
    logic          busy_o, done_o, rd_en_o, valid_o, sof_o, eol_o;
    logic [AW-1:0] rd_addr_o;
    logic [7:0]    rd_data_i, pixel_o;

    logic          start1, ready1;
    logic          busy1, done1, rd_en1, valid1, sof1, eol1;
    logic [0:0]    rd_addr1;
    logic [7:0]    rd_data1, pixel1;

    int total = 0;
    int bad   = 0;
    int rdy_mode = 0;

    always #5 clk = ~clk;

    pixel_frame_streamer #(.IMAGE_LEN(L), .IMAGE_HEIGHT(H), .PIXEL_W(8), .ADDR_W(AW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .pixel_o(pixel_o), .valid_o(valid_o), .ready_i(ready_i), .sof_o(sof_o), .eol_o(eol_o)
    );

    pixel_frame_streamer #(.IMAGE_LEN(1), .IMAGE_HEIGHT(1), .PIXEL_W(8), .ADDR_W(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .busy_o(busy1), .done_o(done1),
        .rd_en_o(rd_en1), .rd_addr_o(rd_addr1), .rd_data_i(rd_data1),
        .pixel_o(pixel1), .valid_o(valid1), .ready_i(ready1), .sof_o(sof1), .eol_o(eol1)
    );

    // Frame RAM: content equals address; output is junk when not read.
    always @(posedge clk) begin
        rd_data_i <= rd_en_o ? 8'(rd_addr_o) : 8'($urandom);
        rd_data1  <= rd_en1  ? 8'(rd_addr1)  : 8'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the 4x3 stream, evaluated once per cycle.
    int   cyc = 0;
    int   m_busy = 0, m_done_due = 0, m_idx = 0, m_issued = 0, m_dones = 0;
    int   m_start = 0, m_first_rd = -1, m_first_valid = -1, m_done_rel = -1;
    bit   m_hold = 0, h_sof, h_eol;
    logic [7:0] h_pix;

    always @(negedge clk) begin
        bit last, idle;
        cyc++;
        last = 0;
        if (!rst_n) begin
            chk("rst_outs", {busy_o, done_o, rd_en_o, valid_o, sof_o, eol_o,
                             |rd_addr_o, |pixel_o}, 0);
            m_busy = 0; m_done_due = 0; m_idx = 0; m_issued = 0; m_hold = 0;
        end else begin
            chk("busy", busy_o, m_busy);
            chk("done", done_o, m_done_due);
            if (m_done_due) begin
                m_dones++;
                m_done_rel = cyc - m_start;
            end
            if (m_hold)
                chk("stall_stable", {valid_o, sof_o, eol_o, pixel_o}, {1'b1, h_sof, h_eol, h_pix});
            if (rd_en_o) begin
                chk("rd_issue_ok", (m_busy != 0) && (m_issued < N), 1);
                chk("rd_addr", rd_addr_o, m_issued);
                if (m_first_rd < 0) m_first_rd = cyc - m_start;
                m_issued++;
            end
            if (valid_o) begin
                chk("valid_in_frame", m_busy != 0, 1);
                if (m_first_valid < 0) m_first_valid = cyc - m_start;
            end
            if (valid_o && ready_i) begin
                chk("pixel", pixel_o, m_idx % 256);
                chk("sof", sof_o, m_idx == 0);
                chk("eol", eol_o, (m_idx % L) == L - 1);
                if (m_idx == N - 1) last = 1;
                m_idx++;
            end
            chk("outstanding", (m_issued - m_idx) <= 2, 1);
            idle   = (m_busy == 0) && (m_done_due == 0);
            m_hold = valid_o && !ready_i;
            h_sof  = sof_o; h_eol = eol_o; h_pix = pixel_o;
            m_done_due = last;
            if (last) m_busy = 0;
            if (idle && start_i) begin
                m_busy = 1; m_start = cyc; m_idx = 0; m_issued = 0;
                m_first_rd = -1; m_first_valid = -1; m_done_rel = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = 1'($urandom_range(0, 1));
            default: ready_i = 1'b0;
        endcase
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = m_dones;
        int n  = 0;
        while (m_dones == d0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_timeout", m_dones != d0, 1);
    endtask

    task automatic wait_idx(input int target);
        int n = 0;
        while (m_idx < target && n < 200) begin
            tick();
            n++;
        end
        chk("idx_timeout", m_idx >= target, 1);
    endtask

    task automatic check_zero();
        chk("z_busy", busy_o, 0);
        chk("z_done", done_o, 0);
        chk("z_rd_en", rd_en_o, 0);
        chk("z_rd_addr", rd_addr_o, 0);
        chk("z_valid", valid_o, 0);
        chk("z_pixel", pixel_o, 0);
        chk("z_sof", sof_o, 0);
        chk("z_eol", eol_o, 0);
    endtask

    // Per-cycle {busy, done, rd_en, valid, sof, eol} of the 1x1 instance with
    // start held high from cycle 0.
    logic [5:0] exp1 [10];

    initial begin
        int d0, n;
        exp1 = '{6'b000000, 6'b101000, 6'b100000, 6'b100111, 6'b010000,
                 6'b000000, 6'b101000, 6'b100000, 6'b100111, 6'b010000};
        rst_n = 1'b0; start_i = 1'b0; ready_i = 1'b1; start1 = 1'b0; ready1 = 1'b1;
        repeat (3) tick();
        check_zero();
        rst_n = 1'b1;
        tick();

        // Full-rate frame with hand-computed timing.
        d0 = m_dones;
        pulse_start();
        wait_done(100);
        chk("lat_rd", m_first_rd, 1);
        chk("lat_valid", m_first_valid, 3);
        chk("lat_done", m_done_rel, 15);
        chk("frameA_xfers", m_idx, N);
        chk("frameA_dones", m_dones - d0, 1);

        // Random backpressure.
        rdy_mode = 1;
        tick();
        pulse_start();
        wait_done(400);
        chk("frameB_xfers", m_idx, N);

        // Long stall right after the first valid beat.
        rdy_mode = 2;
        tick();
        pulse_start();
        n = 0;
        while (!valid_o && n < 20) begin
            tick();
            n++;
        end
        chk("stall_valid_seen", valid_o, 1);
        repeat (10) tick();
        chk("stall_reads", m_issued, 2);
        chk("stall_xfers", m_idx, 0);
        rdy_mode = 0;
        wait_done(100);
        chk("frameC_xfers", m_idx, N);

        // Start pulsed again mid-frame is ignored.
        rdy_mode = 1;
        d0 = m_dones;
        pulse_start();
        wait_idx(4);
        pulse_start();
        wait_done(400);
        repeat (20) tick();
        chk("frameD_xfers", m_idx, N);
        chk("frameD_dones", m_dones - d0, 1);

        // Asynchronous reset mid-frame, then restart.
        d0 = m_dones;
        pulse_start();
        wait_idx(6);
        rst_n = 1'b0;
        #1;
        check_zero();
        tick();
        tick();
        rst_n = 1'b1;
        rdy_mode = 0;
        tick();
        pulse_start();
        wait_done(100);
        chk("restart_xfers", m_idx, N);
        chk("restart_valid_lat", m_first_valid, 3);
        chk("restart_dones", m_dones - d0, 1);

        // Random frames with random gaps.
        for (int f = 0; f < 4; f++) begin
            rdy_mode = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 5)) tick();
            pulse_start();
            wait_done(400);
            chk("rand_xfers", m_idx, N);
        end

        // Start held high: back-to-back frames.
        rdy_mode = 1;
        d0 = m_dones;
        start_i = 1'b1;
        wait_done(400);
        wait_done(400);
        start_i = 1'b0;
        repeat (30) tick();
        chk("b2b_dones", m_dones - d0, 2);

        // Degenerate 1x1 instance, start held high for two frames.
        rdy_mode = 0;
        tick();
        start1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("dg_flags", {busy1, done1, rd_en1, valid1, sof1, eol1}, exp1[k]);
            if (valid1) chk("dg_pixel", pixel1, 0);
            if (rd_en1) chk("dg_addr", rd_addr1, 0);
            @(posedge clk);
            #1;
        end
        start1 = 1'b0;
        repeat (5) tick();
        chk("dg_idle", {busy1, valid1, rd_en1}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
